pe_8: RTL and testbench
=======================

# pe_8

Registered 8-input priority encoder. Each clock it samples an 8-bit request vector and reports the index of the highest-numbered asserted bit, a valid flag, a one-hot grant and a multiple-request flag. It is a leaf arbitration/encode block: requesters drive `A`, and downstream logic consumes `Y`/`V` one cycle later.

## Interface
Parameters:
- `MSB_FIRST`, default 1. When 1, bit 7 has highest priority. When 0, bit 0 has highest priority.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset. One clock; reset is asynchronous and active-low.
- `en`  input  1  sample enable. When low, all outputs hold.
- `A`  input  8  request vector. Bit i high means request i is active.
- `Y`  output  3  encoded index of the winning request.
- `V`  output  1  valid. High when any bit of `A` was set.
- `G`  output  8  one-hot grant. Bit `Y` is set when `V`=1; all zero otherwise.
- `M`  output  1  multiple. High when two or more bits of `A` were set.

## Operation
- Combinational stage:
  - With `MSB_FIRST`=1, the winner is the highest index i with A[i]=1.
  - With `MSB_FIRST`=0, the winner is the lowest such index.
  - `V_next` = OR of all bits of `A`.
  - `M_next` = 1 iff popcount(A) ≥ 2.
  - `G_next` = 1 << winner when `V_next`=1, else 8'h00.
  - `Y_next` = winner when `V_next`=1, else 3'd0.
- Register stage: on rising `clk` with `en`=1, `Y`/`V`/`G`/`M` load their `_next` values. With `en`=0 they retain their previous values.
- Invariants, holding on every cycle:
  - `G` is either zero or exactly one-hot.
  - `V`=0 implies `Y`=0, `G`=0 and `M`=0.
  - `V`=1 implies `G[Y]`=1.
- `A` is treated as fully asynchronous data. It needs no handshake or stability requirement beyond setup/hold at the sampling edge.
- No X-propagation tolerance is required. `A` must be a known value whenever `en`=1.

## Timing
- Latency is 1 cycle. `A` sampled at edge k appears on the outputs after edge k and stays stable until edge k+1.
- Throughput is one new vector per cycle. Back-to-back changes of `A` are each reflected one cycle later.
- Reset:
  - `rst_n` low immediately (asynchronously) forces `Y`=3'd0, `V`=0, `G`=8'h00, `M`=0, regardless of `clk` and `en`.
  - Outputs remain at these values while `rst_n` is low.
  - The first load occurs on the first rising `clk` with `rst_n` high and `en`=1.
- Reset asserted mid-stream: the in-flight result is discarded, with no partial update.
- `en` low for N cycles: outputs frozen for N cycles. The next enabled edge samples the current `A`; stale values are not sampled.
- All output paths are registered, so there is no combinational path from `A` or `en` to any output.

## Test plan
- Reset: drive `rst_n`=0 with `A`=8'hFF, `en`=1 → `Y`=0, `V`=0, `G`=8'h00, `M`=0 while `rst_n` is low, including before any clock edge.
- Walking one, `MSB_FIRST`=1: `A` = 8'h00, 01, 02, 04, 08, 10, 20, 40, 80 on successive cycles → one cycle later:
  - `V`=0, `Y`=0 for 8'h00.
  - Then `Y`=0..7 with `V`=1, `G` equal to `A` and `M`=0.
- Multiple requests, `MSB_FIRST`=1:
  - `A`=8'b00000101 → `Y`=2, `V`=1, `G`=8'h04, `M`=1.
  - `A`=8'b10000001 → `Y`=7, `G`=8'h80, `M`=1.
- Priority direction, `MSB_FIRST`=0: `A`=8'b10000001 → `Y`=0, `G`=8'h01, `M`=1. `A`=8'b01100000 → `Y`=5, `G`=8'h20.
- Enable hold: load `A`=8'h40 (`Y`=6), then set `en`=0 and `A`=8'h01 for 3 cycles → `Y` stays 6, `V`=1. Raise `en` → next cycle `Y`=0.
- Async reset mid-stream: with `Y`=7, `V`=1, pulse `rst_n` low between clock edges → outputs clear immediately. After release with `A`=8'h10 → `Y`=4 one cycle later.

Source files
------------

// File: rtl/pe_8_if.sv
// pe_8 request/result bundle.
// Requester drives en/A; encoder returns Y/V/G/M.
interface pe_8_if;
  logic       en;
  logic [7:0] A;
  logic [2:0] Y;
  logic       V;
  logic [7:0] G;
  logic       M;

  modport master (
    output en,
    output A,
    input  Y,
    input  V,
    input  G,
    input  M
  );

  modport slave (
    input  en,
    input  A,
    output Y,
    output V,
    output G,
    output M
  );
endinterface

// File: rtl/pe_8.sv
// Registered 8-input priority encoder.
// Index, valid, one-hot grant and multi-request flag.
module pe_8 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,
  pe_8_if.slave  bus
);

  logic [2:0] y_q, y_d;
  logic       v_q, v_d;
  logic [7:0] g_q, g_d;
  logic       m_q, m_d;
  logic [3:0] cnt;

  // Find the winning index and count active requests.
  always_comb begin
    y_d = 3'd0;
    v_d = |bus.A;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, bus.A[i]};
      if (MSB_FIRST) begin
        if (bus.A[i]) y_d = 3'(i);
      end else begin
        if (bus.A[7-i]) y_d = 3'(7 - i);
      end
    end
    m_d = (cnt >= 4'd2);
    g_d = v_d ? (8'd1 << y_d) : 8'd0;
  end

  // Load results on enabled edges; async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 3'd0;
      v_q <= 1'b0;
      g_q <= 8'd0;
      m_q <= 1'b0;
    end else if (bus.en) begin
      y_q <= y_d;
      v_q <= v_d;
      g_q <= g_d;
      m_q <= m_d;
    end
  end

  assign bus.Y = y_q;
  assign bus.V = v_q;
  assign bus.G = g_q;
  assign bus.M = m_q;

endmodule

// File: tb/tb_pe_8.sv
// Bench for pe_8: directed cases plus random
// stimulus against a behavioural model.
module tb_pe_8;

  typedef struct packed {
    logic [2:0] y;
    logic       v;
    logic [7:0] g;
    logic       m;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] a;
  bit         chk_on = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  res_t       exp1 = '0;
  res_t       exp0 = '0;

  pe_8_if b1();
  pe_8_if b0();

  assign b1.en = en;
  assign b1.A  = a;
  assign b0.en = en;
  assign b0.A  = a;

  pe_8 #(.MSB_FIRST(1'b1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  pe_8 #(.MSB_FIRST(1'b0)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  always #5 clk = ~clk;

  function automatic res_t model_f(input logic [7:0] v,
                                   input bit msb);
    res_t r;
    int   w;
    r = '0;
    w = -1;
    if (msb) begin
      for (int i = 7; i >= 0 && w < 0; i--)
        if (v[i]) w = i;
    end else begin
      for (int i = 0; i <= 7 && w < 0; i++)
        if (v[i]) w = i;
    end
    if (w >= 0) begin
      r.v = 1'b1;
      r.y = 3'(w);
      r.g = 8'd1 << w;
    end
    r.m = ($countones(v) >= 2);
    return r;
  endfunction

  function automatic res_t dut1();
    return '{b1.Y, b1.V, b1.G, b1.M};
  endfunction

  function automatic res_t dut0();
    return '{b0.Y, b0.V, b0.G, b0.M};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h t=%0t",
               nm, act, want, $time);
    end
  endtask

  // Reference: what the outputs must show after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp1 <= '0;
      exp0 <= '0;
    end else if (en) begin
      exp1 <= model_f(a, 1'b1);
      exp0 <= model_f(a, 1'b0);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_msb", 32'(dut1()), 32'(exp1));
      chk("model_lsb", 32'(dut0()), 32'(exp0));
      chk("inv_msb", 32'(
        $onehot0(b1.G) &&
        (b1.V ? b1.G[b1.Y] :
         (b1.Y == 3'd0 && b1.G == 8'd0 && !b1.M))),
        32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] wv;
    rst_n = 1'b0;
    en    = 1'b1;
    a     = 8'hFF;
    #1;
    chk("rst_pre_edge", 32'(dut1()), 32'd0);
    chk("rst_pre_edge0", 32'(dut0()), 32'd0);
    chk_on = 1'b1;
    step();
    step();
    chk("rst_held", 32'(dut1()), 32'd0);
    rst_n = 1'b1;

    // Walking one.
    for (int i = -1; i < 8; i++) begin
      wv = (i < 0) ? 8'h00 : (8'd1 << i);
      a = wv;
      step();
      if (i < 0) begin
        chk("walk_v0", 32'(b1.V), 32'd0);
        chk("walk_y0", 32'(b1.Y), 32'd0);
      end else begin
        chk("walk_y", 32'(b1.Y), 32'(i));
        chk("walk_g", 32'(b1.G), 32'(wv));
        chk("walk_vm", 32'({b1.V, b1.M}), 32'b10);
      end
    end

    a = 8'b0000_0101;
    step();
    chk("multi_05", 32'(dut1()),
        32'({3'd2, 1'b1, 8'h04, 1'b1}));
    a = 8'b1000_0001;
    step();
    chk("multi_81", 32'(dut1()),
        32'({3'd7, 1'b1, 8'h80, 1'b1}));
    chk("lsb_81", 32'(dut0()),
        32'({3'd0, 1'b1, 8'h01, 1'b1}));
    a = 8'b0110_0000;
    step();
    chk("lsb_60_y", 32'(b0.Y), 32'd5);
    chk("lsb_60_g", 32'(b0.G), 32'h20);

    // Enable hold.
    a = 8'h40;
    step();
    chk("hold_load", 32'(b1.Y), 32'd6);
    en = 1'b0;
    a  = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_y", 32'(b1.Y), 32'd6);
      chk("hold_v", 32'(b1.V), 32'd1);
    end
    en = 1'b1;
    step();
    chk("hold_release", 32'(b1.Y), 32'd0);

    // Async reset between edges.
    a = 8'h80;
    step();
    chk("pre_rst_y7", 32'(b1.Y), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", 32'(dut1()), 32'd0);
    chk("async_clear0", 32'(dut0()), 32'd0);
    a = 8'h10;
    #3;
    rst_n = 1'b1;
    step();
    chk("post_rst_y4", 32'(b1.Y), 32'd4);

    // Random traffic with occasional reset pulses.
    for (int k = 0; k < 2000; k++) begin
      a  = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        a = 8'($urandom) & 8'($urandom);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
